// File: rtl/mem_pkg.sv
// Shared types and encodings for the non-blocking MEM stage: memory op codes,
// queue entry layout and SRAM-bus size/strobe helpers.
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LD_B     = 4'd1,
    LD_BU    = 4'd2,
    LD_H     = 4'd3,
    LD_HU    = 4'd4,
    LD_W     = 4'd5,
    ST_B     = 4'd6,
    ST_H     = 4'd7,
    ST_W     = 4'd8
  } mem_op_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [3:0] WSTRB_B0 = 4'b0001;
  localparam logic [3:0] WSTRB_HL = 4'b0011;
  localparam logic [3:0] WSTRB_HH = 4'b1100;
  localparam logic [3:0] WSTRB_W  = 4'b1111;
  localparam logic [3:0] WSTRB_LD = 4'b0000;

  localparam int EXC_ALE_BIT = 0;

  // Exception payload is kept in a separate array because its width is a module parameter.
  typedef struct packed {
    mem_op_t     op;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        gr_we;
  } mem_entry_t;

  function automatic logic is_load(input mem_op_t op);
    return op inside {LD_B, LD_BU, LD_H, LD_HU, LD_W};
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return op inside {ST_B, ST_H, ST_W};
  endfunction

  function automatic logic is_mem(input mem_op_t op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic [1:0] op_size(input mem_op_t op);
    case (op)
      LD_B, LD_BU, ST_B: return SIZE_B;
      LD_H, LD_HU, ST_H: return SIZE_H;
      default:           return SIZE_W;
    endcase
  endfunction

  function automatic logic [3:0] op_wstrb(input mem_op_t op, input logic [1:0] a);
    logic [3:0] one;
    one = WSTRB_B0;
    case (op)
      ST_B:    return one << a;
      ST_H:    return a[1] ? WSTRB_HH : WSTRB_HL;
      ST_W:    return WSTRB_W;
      default: return WSTRB_LD;
    endcase
  endfunction

  function automatic logic [31:0] op_wdata(input mem_op_t op, input logic [31:0] d);
    case (op)
      ST_B:    return {4{d[7:0]}};
      ST_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_nb_if.sv
// SRAM-like data bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_nb_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/mem_stage_nb_ld_align.sv
// mem_ld_align: selects the addressed byte/half of a load response and
// sign- or zero-extends it to 32 bits.
module mem_ld_align
  import mem_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (addr)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      LD_B:    data = {{24{b[7]}}, b};
      LD_BU:   data = {24'd0, b};
      LD_H:    data = {{16{h[15]}}, h};
      LD_HU:   data = {16'd0, h};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/mem_stage_nb.sv
// mem_stage_nb: in-order, non-blocking MEM stage with a DEPTH-entry queue that
// overlaps bus address/data phases. Optional MEM_PERF_CNT_EN adds perf counters.
module mem_stage_nb
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int EXC_W = 87
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  mem_op_t          in_op,
  input  logic [31:0]      in_result,
  input  logic [31:0]      in_wdata,
  input  logic             in_gr_we,
  input  logic [4:0]       in_rd,
  input  logic [EXC_W-1:0] in_exc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic             out_gr_we,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_wdata,
  output logic [EXC_W-1:0] out_exc,
  output logic [31:0]      out_badv,
  input  logic             flush,
  mem_stage_nb_if.master   bus,
  input  logic [4:0]       q_raddr1,
  input  logic [4:0]       q_raddr2,
  output logic             load_hazard,
`ifdef MEM_PERF_CNT_EN
  output logic [31:0]      perf_req_cnt,
  output logic [31:0]      perf_stall_cnt,
`endif
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [31:0]      fwd_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  mem_entry_t       ent    [DEPTH];
  logic [EXC_W-1:0] exc    [DEPTH];
  logic [31:0]      data   [DEPTH];
  logic [DEPTH-1:0] exc_nz;
  logic [DEPTH-1:0] issued;
  logic [DEPTH-1:0] done;

  logic [PW-1:0] head, tail, iss, cmp_idx;
  logic [CW-1:0] count, iss_cnt, cancel_cnt, cancel_nxt, inflight;

  logic        req_hold, hold_wr;
  logic [1:0]  hold_size;
  logic [3:0]  hold_wstrb;
  logic [31:0] hold_addr, hold_wdata;

  logic        lv_wr;
  logic [1:0]  lv_size;
  logic [3:0]  lv_wstrb;
  logic [31:0] lv_addr, lv_wdata, ld_data;

  logic iss_live, older_exc, cmp_found, can_req, skip, live_hs, iss_adv;
  logic drop, live_dok, pop, enq;

  // Scan live entries from head: older exceptions, in-flight requests, oldest
  // pending response target and load-use hazard.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = head;
    older_exc   = 1'b0;
    inflight    = '0;
    cmp_found   = 1'b0;
    cmp_idx     = head;
    load_hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count) begin
        if (CW'(k) < iss_cnt && exc_nz[idx]) older_exc = 1'b1;
        if (issued[idx] && !done[idx]) begin
          inflight = inflight + CW'(1);
          if (!cmp_found) begin
            cmp_found = 1'b1;
            cmp_idx   = idx;
          end
        end
        if (is_load(ent[idx].op) && !done[idx] &&
            ((q_raddr1 != 5'd0 && ent[idx].rd == q_raddr1) ||
             (q_raddr2 != 5'd0 && ent[idx].rd == q_raddr2)))
          load_hazard = 1'b1;
      end
    end
  end

  assign iss_live = iss_cnt < count;
  assign skip     = iss_live && (!is_mem(ent[iss].op) || done[iss]);
  // Cancelled responses still occupy bus slots, so they count against DEPTH.
  assign can_req  = iss_live && is_mem(ent[iss].op) && !issued[iss] && !done[iss] &&
                    !older_exc && !req_hold &&
                    (({1'b0, cancel_cnt} + {1'b0, inflight}) < (CW+1)'(DEPTH));
  assign live_hs  = can_req && bus.data_sram_addr_ok;
  assign iss_adv  = skip || live_hs;

  assign drop     = bus.data_sram_data_ok && (cancel_cnt != '0);
  assign live_dok = bus.data_sram_data_ok && !drop && cmp_found;

  assign out_valid = (count != '0) && done[head];
  assign pop       = out_valid && out_ready;
  assign in_ready  = (count < CW'(DEPTH)) && !flush;
  assign enq       = in_valid && in_ready;

  always_comb begin
    lv_wr    = is_store(ent[iss].op);
    lv_size  = op_size(ent[iss].op);
    lv_wstrb = op_wstrb(ent[iss].op, ent[iss].addr[1:0]);
    lv_addr  = ent[iss].addr;
    lv_wdata = op_wdata(ent[iss].op, ent[iss].wdata);
  end

  always_comb begin
    bus.data_sram_req   = req_hold || can_req;
    bus.data_sram_wr    = 1'b0;
    bus.data_sram_size  = 2'd0;
    bus.data_sram_wstrb = 4'd0;
    bus.data_sram_addr  = 32'd0;
    bus.data_sram_wdata = 32'd0;
    if (req_hold) begin
      bus.data_sram_wr    = hold_wr;
      bus.data_sram_size  = hold_size;
      bus.data_sram_wstrb = hold_wstrb;
      bus.data_sram_addr  = hold_addr;
      bus.data_sram_wdata = hold_wdata;
    end else if (can_req) begin
      bus.data_sram_wr    = lv_wr;
      bus.data_sram_size  = lv_size;
      bus.data_sram_wstrb = lv_wstrb;
      bus.data_sram_addr  = lv_addr;
      bus.data_sram_wdata = lv_wdata;
    end
  end

  always_comb begin
    cancel_nxt = cancel_cnt;
    if (flush) cancel_nxt = cancel_nxt + inflight + CW'(live_hs) - CW'(live_dok);
    if (req_hold && bus.data_sram_addr_ok) cancel_nxt = cancel_nxt + CW'(1);
    if (drop) cancel_nxt = cancel_nxt - CW'(1);
  end

  mem_ld_align u_ld_align (
    .op    (ent[cmp_idx].op),
    .addr  (ent[cmp_idx].addr[1:0]),
    .rdata (bus.data_sram_rdata),
    .data  (ld_data)
  );

  // Control state: pointers, counters and per-entry flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head       <= '0;
      tail       <= '0;
      iss        <= '0;
      count      <= '0;
      iss_cnt    <= '0;
      cancel_cnt <= '0;
      req_hold   <= 1'b0;
      issued     <= '0;
      done       <= '0;
    end else begin
      cancel_cnt <= cancel_nxt;
      if (flush) begin
        head    <= '0;
        tail    <= '0;
        iss     <= '0;
        count   <= '0;
        iss_cnt <= '0;
      end else begin
        if (enq) tail <= tail + PW'(1);
        if (pop) head <= head + PW'(1);
        if (iss_adv) iss <= iss + PW'(1);
        count   <= count + CW'(enq) - CW'(pop);
        iss_cnt <= iss_cnt + CW'(iss_adv) - CW'(pop);
      end
      if (req_hold && bus.data_sram_addr_ok) req_hold <= 1'b0;
      else if (flush && can_req && !bus.data_sram_addr_ok) req_hold <= 1'b1;
      if (live_hs) issued[iss] <= 1'b1;
      if (live_dok) done[cmp_idx] <= 1'b1;
      if (enq) begin
        issued[tail] <= 1'b0;
        done[tail]   <= (in_op == MEM_NONE) || in_exc[EXC_ALE_BIT];
      end
    end
  end

  // Entry payload and held request fields.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent[tail]    <= '{op: in_op, pc: in_pc, addr: in_result, wdata: in_wdata,
                        rd: in_rd, gr_we: in_gr_we};
      exc[tail]    <= in_exc;
      exc_nz[tail] <= |in_exc;
      data[tail]   <= in_result;
    end
    if (live_dok) data[cmp_idx] <= is_load(ent[cmp_idx].op) ? ld_data : 32'd0;
    if (flush && can_req && !bus.data_sram_addr_ok) begin
      hold_wr    <= lv_wr;
      hold_size  <= lv_size;
      hold_wstrb <= lv_wstrb;
      hold_addr  <= lv_addr;
      hold_wdata <= lv_wdata;
    end
  end

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_req_cnt   <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (bus.data_sram_req && bus.data_sram_addr_ok) perf_req_cnt <= perf_req_cnt + 32'd1;
      if (in_valid && !in_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  assign out_pc    = out_valid ? ent[head].pc    : 32'd0;
  assign out_gr_we = out_valid ? ent[head].gr_we : 1'b0;
  assign out_rd    = out_valid ? ent[head].rd    : 5'd0;
  assign out_wdata = out_valid ? data[head]      : 32'd0;
  assign out_exc   = out_valid ? exc[head]       : '0;
  assign out_badv  = out_valid ? ent[head].addr  : 32'd0;

  assign fwd_valid = out_valid && ent[head].gr_we;
  assign fwd_rd    = fwd_valid ? ent[head].rd : 5'd0;
  assign fwd_data  = fwd_valid ? data[head]   : 32'd0;
endmodule

// File: tb/tb_mem_stage_nb.sv
// Directed bench for mem_stage_nb: load extension, store encoding, back-to-back
// issue, flush with response cancellation, ALE blocking, WB stall and held request.
module tb_mem_stage_nb;
  import mem_pkg::*;

  localparam int EXC_W = 87;

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid, in_ready, in_gr_we;
  logic [31:0]      in_pc, in_result, in_wdata;
  mem_op_t          in_op;
  logic [4:0]       in_rd;
  logic [EXC_W-1:0] in_exc;
  logic             out_valid, out_ready, out_gr_we;
  logic [31:0]      out_pc, out_wdata, out_badv;
  logic [4:0]       out_rd;
  logic [EXC_W-1:0] out_exc;
  logic             flush;
  logic [4:0]       q_raddr1, q_raddr2;
  logic             load_hazard, fwd_valid;
  logic [4:0]       fwd_rd;
  logic [31:0]      fwd_data;
`ifdef MEM_PERF_CNT_EN
  logic [31:0]      perf_req_cnt, perf_stall_cnt;
`endif

  int total  = 0;
  int passes = 0;

  mem_stage_nb_if bus ();

  mem_stage_nb #(.DEPTH(4), .EXC_W(EXC_W)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op),
    .in_result(in_result), .in_wdata(in_wdata), .in_gr_we(in_gr_we), .in_rd(in_rd),
    .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_gr_we(out_gr_we),
    .out_rd(out_rd), .out_wdata(out_wdata), .out_exc(out_exc), .out_badv(out_badv),
    .flush(flush), .bus(bus), .q_raddr1(q_raddr1), .q_raddr2(q_raddr2),
    .load_hazard(load_hazard),
`ifdef MEM_PERF_CNT_EN
    .perf_req_cnt(perf_req_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic send(input mem_op_t op, input logic [31:0] pc, input logic [31:0] res,
                      input logic [31:0] wd, input logic [4:0] rd, input logic we,
                      input logic [EXC_W-1:0] ex);
    in_valid  = 1'b1;
    in_op     = op;
    in_pc     = pc;
    in_result = res;
    in_wdata  = wd;
    in_rd     = rd;
    in_gr_we  = we;
    in_exc    = ex;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b0; q_raddr1 = 5'd0; q_raddr2 = 5'd0;
    in_valid = 1'b0; in_op = MEM_NONE; in_pc = 32'd0; in_result = 32'd0; in_wdata = 32'd0;
    in_rd = 5'd0; in_gr_we = 1'b0; in_exc = '0;
    bus.data_sram_addr_ok = 1'b0; bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = 32'd0;
    step(); step();
    resetn = 1'b1;

    // Reset state
    mid();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req", bus.data_sram_req, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_wdata", out_wdata, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_hazard", load_hazard, 0);
    step();

    // ld.b at ...03, immediate addr_ok/data_ok, then WB stall for 10 cycles
    send(LD_B, 32'h1c00_0000, 32'h1000_0003, 32'd0, 5'd5, 1'b1, '0);
    bus.data_sram_addr_ok = 1'b1; q_raddr1 = 5'd5;
    mid(); chk("ldb_in_ready", in_ready, 1); step();
    idle();
    mid();
    chk("ldb_req", bus.data_sram_req, 1);
    chk("ldb_size", bus.data_sram_size, 0);
    chk("ldb_wstrb", bus.data_sram_wstrb, 0);
    chk("ldb_wr", bus.data_sram_wr, 0);
    chk("ldb_addr", bus.data_sram_addr, 32'h1000_0003);
    chk("ldb_hazard", load_hazard, 1);
    chk("ldb_nvalid1", out_valid, 0);
    step();
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h80FF_0000;
    mid(); chk("ldb_noreq", bus.data_sram_req, 0); chk("ldb_nvalid2", out_valid, 0); step();
    bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = 32'd0;
    for (int i = 0; i < 10; i++) begin
      mid();
      chk("stall_valid", out_valid, 1);
      chk("stall_wdata", out_wdata, 32'hFFFF_FF80);
      chk("stall_pc", out_pc, 32'h1c00_0000);
      chk("stall_badv", out_badv, 32'h1000_0003);
      chk("stall_fwd_valid", fwd_valid, 1);
      chk("stall_fwd_rd", fwd_rd, 5);
      chk("stall_fwd_data", fwd_data, 32'hFFFF_FF80);
      chk("stall_hazard", load_hazard, 0);
      step();
    end
    out_ready = 1'b1;
    mid(); chk("ldb_pop_valid", out_valid, 1); step();
    mid(); chk("ldb_empty", out_valid, 0); chk("ldb_fwd_off", fwd_valid, 0); step();
    q_raddr1 = 5'd0;

    // Non-memory op: one cycle through
    send(MEM_NONE, 32'h1c00_0010, 32'hDEAD_BEEF, 32'd0, 5'd3, 1'b1, '0);
    mid(); step();
    idle();
    mid();
    chk("alu_valid", out_valid, 1);
    chk("alu_wdata", out_wdata, 32'hDEAD_BEEF);
    chk("alu_rd", out_rd, 3);
    chk("alu_noreq", bus.data_sram_req, 0);
    step();
    mid(); chk("alu_gone", out_valid, 0); step();

    // st.h at 0x2: half replicated, upper strobes, addr_ok withheld one cycle
    bus.data_sram_addr_ok = 1'b0;
    send(ST_H, 32'h1c00_0020, 32'h0000_0002, 32'hABCD_1234, 5'd0, 1'b0, '0);
    mid(); step();
    idle();
    mid();
    chk("sth_req", bus.data_sram_req, 1);
    chk("sth_wr", bus.data_sram_wr, 1);
    chk("sth_size", bus.data_sram_size, 1);
    chk("sth_wstrb", bus.data_sram_wstrb, 4'b1100);
    chk("sth_wdata", bus.data_sram_wdata, 32'h1234_1234);
    chk("sth_addr", bus.data_sram_addr, 32'h2);
    step();
    bus.data_sram_addr_ok = 1'b1;
    mid(); chk("sth_req_held", bus.data_sram_req, 1); step();
    bus.data_sram_data_ok = 1'b1;
    mid(); chk("sth_req_done", bus.data_sram_req, 0); step();
    bus.data_sram_data_ok = 1'b0;
    mid();
    chk("sth_valid", out_valid, 1);
    chk("sth_wdata_wb", out_wdata, 0);
    chk("sth_gr_we", out_gr_we, 0);
    step();
    mid(); chk("sth_gone", out_valid, 0); step();

    // Four ld.w back-to-back, fifth refused, data_ok 5 cycles after first req
    for (int i = 0; i < 4; i++) begin
      send(LD_W, 32'h1c00_0100 + 32'(4*i), 32'h100 + 32'(4*i), 32'd0, 5'(i+1), 1'b1, '0);
      mid();
      chk("b2b_in_ready", in_ready, 1);
      if (i > 0) begin
        chk("b2b_req", bus.data_sram_req, 1);
        chk("b2b_addr", bus.data_sram_addr, 32'h100 + 32'(4*(i-1)));
      end
      step();
    end
    send(LD_W, 32'h1c00_0110, 32'h110, 32'd0, 5'd9, 1'b1, '0);
    mid();
    chk("b2b_full", in_ready, 0);
    chk("b2b_req4", bus.data_sram_req, 1);
    chk("b2b_addr4", bus.data_sram_addr, 32'h10C);
    step();
    idle();
    mid(); chk("b2b_noreq", bus.data_sram_req, 0); chk("b2b_wait", out_valid, 0); step();
    for (int i = 0; i < 4; i++) begin
      bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h1111_0000 + 32'(i);
      mid();
      if (i > 0) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_data", out_wdata, 32'h1111_0000 + 32'(i-1));
        chk("b2b_rd", out_rd, 5'(i));
      end
      step();
    end
    bus.data_sram_data_ok = 1'b0;
    mid();
    chk("b2b_valid_last", out_valid, 1);
    chk("b2b_data_last", out_wdata, 32'h1111_0003);
    chk("b2b_rd_last", out_rd, 4);
    step();
    mid(); chk("b2b_drained", out_valid, 0); chk("b2b_no5th", bus.data_sram_req, 0); step();

    // Two loads issued, flush, new load: first two responses dropped
    send(LD_W, 32'h1c00_0200, 32'h200, 32'd0, 5'd6, 1'b1, '0);
    mid(); step();
    send(LD_W, 32'h1c00_0204, 32'h204, 32'd0, 5'd7, 1'b1, '0);
    mid(); chk("fl_req0", bus.data_sram_addr, 32'h200); step();
    idle();
    mid(); chk("fl_req1", bus.data_sram_addr, 32'h204); step();
    flush = 1'b1;
    send(MEM_NONE, 32'h1c00_0208, 32'h55, 32'd0, 5'd12, 1'b1, '0);
    mid(); chk("fl_in_ready", in_ready, 0); chk("fl_noreq", bus.data_sram_req, 0); step();
    flush = 1'b0;
    send(LD_W, 32'h1c00_0300, 32'h300, 32'd0, 5'd8, 1'b1, '0);
    mid(); chk("fl_empty", out_valid, 0); chk("fl_ready", in_ready, 1); step();
    idle();
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h0000_BAD0;
    mid(); chk("fl_newreq", bus.data_sram_req, 1); chk("fl_newaddr", bus.data_sram_addr, 32'h300); step();
    bus.data_sram_rdata = 32'h0000_BAD1;
    mid(); chk("fl_drop1", out_valid, 0); step();
    bus.data_sram_rdata = 32'h0000_600D;
    mid(); chk("fl_drop2", out_valid, 0); step();
    bus.data_sram_data_ok = 1'b0;
    mid();
    chk("fl_valid", out_valid, 1);
    chk("fl_data", out_wdata, 32'h600D);
    chk("fl_rd", out_rd, 8);
    step();
    mid(); chk("fl_gone", out_valid, 0); step();

    // ld.w with ALE then st.w: neither reaches the bus
    out_ready = 1'b0;
    send(LD_W, 32'h1c00_0400, 32'h401, 32'd0, 5'd9, 1'b1, 87'd1);
    mid(); step();
    send(ST_W, 32'h1c00_0404, 32'h500, 32'h0000_CAFE, 5'd0, 1'b0, '0);
    mid();
    chk("ale_noreq0", bus.data_sram_req, 0);
    chk("ale_valid", out_valid, 1);
    chk("ale_badv", out_badv, 32'h401);
    chk("ale_exc", out_exc[31:0], 1);
    step();
    idle();
    mid(); chk("ale_noreq1", bus.data_sram_req, 0); chk("ale_still", out_valid, 1); step();
    out_ready = 1'b1; flush = 1'b1;
    mid(); chk("ale_noreq2", bus.data_sram_req, 0); step();
    flush = 1'b0;
    mid(); chk("ale_noreq3", bus.data_sram_req, 0); chk("ale_gone", out_valid, 0); step();

    // st.b req pending at flush: held until addr_ok, its response dropped
    bus.data_sram_addr_ok = 1'b0;
    send(ST_B, 32'h1c00_0600, 32'h601, 32'h0000_00AB, 5'd0, 1'b0, '0);
    mid(); step();
    idle(); flush = 1'b1;
    mid();
    chk("hold_req", bus.data_sram_req, 1);
    chk("hold_wstrb0", bus.data_sram_wstrb, 4'b0010);
    chk("hold_wdata0", bus.data_sram_wdata, 32'hABAB_ABAB);
    step();
    flush = 1'b0; bus.data_sram_addr_ok = 1'b1;
    mid();
    chk("hold_req1", bus.data_sram_req, 1);
    chk("hold_wr", bus.data_sram_wr, 1);
    chk("hold_addr", bus.data_sram_addr, 32'h601);
    chk("hold_wstrb1", bus.data_sram_wstrb, 4'b0010);
    step();
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hEE;
    send(LD_W, 32'h1c00_0700, 32'h700, 32'd0, 5'd10, 1'b1, '0);
    mid(); chk("hold_clear", bus.data_sram_req, 0); step();
    bus.data_sram_data_ok = 1'b0; idle();
    mid(); chk("hold_newreq", bus.data_sram_req, 1); chk("hold_newaddr", bus.data_sram_addr, 32'h700); step();
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h77;
    mid(); chk("hold_wait", out_valid, 0); step();
    bus.data_sram_data_ok = 1'b0;
    mid(); chk("hold_valid", out_valid, 1); chk("hold_data", out_wdata, 32'h77); step();
    mid(); chk("hold_gone", out_valid, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
